// File: rtl/ctrl_pkg.sv
// Shared opcode/funct constants and the instruction decode for the MIPS pipeline
// control decoder (ctrl_dec).
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;
  localparam logic [5:0] FN_NOP   = 6'b000000;

  typedef struct packed {
    logic r;
    logic addu;
    logic subu;
    logic jr;
    logic jalr;
    logic lw;
    logic sw;
    logic ori;
    logic lui;
    logic addi;
    logic beq;
    logic j;
    logic jal;
    logic ill;
  } ctrl_flags_t;

  function automatic ctrl_flags_t ctrl_decode(input logic [5:0] op, input logic [5:0] func);
    ctrl_flags_t f;
    logic        known;
    f      = '0;
    f.r    = (op == OP_RTYPE);
    // Func only means something for R-type; it is ignored for every other opcode.
    f.addu = f.r && (func == FN_ADDU);
    f.subu = f.r && (func == FN_SUBU);
    f.jr   = f.r && (func == FN_JR);
    f.jalr = f.r && (func == FN_JALR);
    f.lw   = (op == OP_LW);
    f.sw   = (op == OP_SW);
    f.ori  = (op == OP_ORI);
    f.lui  = (op == OP_LUI);
    f.addi = (op == OP_ADDI);
    f.beq  = (op == OP_BEQ);
    f.j    = (op == OP_J);
    f.jal  = (op == OP_JAL);
    known  = f.addu | f.subu | f.jr | f.jalr | f.lw | f.sw | f.ori |
             f.lui | f.addi | f.beq | f.j | f.jal;
    // The all-zero nop is what flushed stages hold, so it must not count as illegal.
    f.ill  = !known && !(f.r && (func == FN_NOP));
    return f;
  endfunction

endpackage

// File: rtl/ctrl_dec.sv
// Per-stage instruction decoder: one flag per instruction, plus illegal/sticky-illegal.
// Define CTRL_REG_OUT_EN to register all flags and ill (one-cycle latency).
module ctrl_dec
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic [5:0] Func,
  output logic       R,
  output logic       addu,
  output logic       subu,
  output logic       jr,
  output logic       jalr,
  output logic       lw,
  output logic       sw,
  output logic       ori,
  output logic       lui,
  output logic       addi,
  output logic       beq,
  output logic       j,
  output logic       jal,
  output logic       ill,
  output logic       ill_seen
);

  ctrl_flags_t dec;
  ctrl_flags_t flags;

  always_comb begin
    dec = ctrl_decode(Op, Func);
  end

`ifdef CTRL_REG_OUT_EN
  // Reset clears every flag, R included, so a stage in reset decodes as nothing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags <= '0;
    end else begin
      flags <= dec;
    end
  end
`else
  assign flags = dec;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ill_seen <= 1'b0;
    end else if (flags.ill) begin
      ill_seen <= 1'b1;
    end
  end

  assign R    = flags.r;
  assign addu = flags.addu;
  assign subu = flags.subu;
  assign jr   = flags.jr;
  assign jalr = flags.jalr;
  assign lw   = flags.lw;
  assign sw   = flags.sw;
  assign ori  = flags.ori;
  assign lui  = flags.lui;
  assign addi = flags.addi;
  assign beq  = flags.beq;
  assign j    = flags.j;
  assign jal  = flags.jal;
  assign ill  = flags.ill;

endmodule

// File: tb/tb_ctrl_dec.sv
// Self-checking bench for ctrl_dec: directed decodes, exhaustive Op/Func sweep,
// and sticky-illegal/reset behaviour; follows CTRL_REG_OUT_EN when defined.
module tb_ctrl_dec;

  logic       clk;
  logic       reset;
  logic [5:0] Op;
  logic [5:0] Func;
  logic       R, addu, subu, jr, jalr, lw, sw, ori, lui, addi, beq, j, jal, ill, ill_seen;

  logic [13:0] obs;
  logic [13:0] exp_q[$];
  int          checks;
  int          failures;

  ctrl_dec dut (
    .clk(clk), .reset(reset), .Op(Op), .Func(Func),
    .R(R), .addu(addu), .subu(subu), .jr(jr), .jalr(jalr),
    .lw(lw), .sw(sw), .ori(ori), .lui(lui), .addi(addi),
    .beq(beq), .j(j), .jal(jal), .ill(ill), .ill_seen(ill_seen)
  );

  // Bit order: R addu subu jr jalr lw sw ori lui addi beq j jal ill
  assign obs = {R, addu, subu, jr, jalr, lw, sw, ori, lui, addi, beq, j, jal, ill};

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model, written from the instruction table independently of the RTL.
  function automatic logic [13:0] model(input logic [5:0] op, input logic [5:0] fn);
    logic [13:0] e;
    e = '0;
    if (op == 6'b000000) begin
      e[13] = 1'b1;
      case (fn)
        6'b100001: e[12] = 1'b1;
        6'b100011: e[11] = 1'b1;
        6'b001000: e[10] = 1'b1;
        6'b001001: e[9]  = 1'b1;
        6'b000000: ;
        default:   e[0]  = 1'b1;
      endcase
    end else begin
      case (op)
        6'b100011: e[8] = 1'b1;
        6'b101011: e[7] = 1'b1;
        6'b001101: e[6] = 1'b1;
        6'b001111: e[5] = 1'b1;
        6'b001000: e[4] = 1'b1;
        6'b000100: e[3] = 1'b1;
        6'b000010: e[2] = 1'b1;
        6'b000011: e[1] = 1'b1;
        default:   e[0] = 1'b1;
      endcase
    end
    return e;
  endfunction

  // Driver: apply one instruction and push its expected flags.
  task automatic drive(input logic [5:0] op, input logic [5:0] fn);
    @(negedge clk);
    Op   = op;
    Func = fn;
    exp_q.push_back(model(op, fn));
`ifdef CTRL_REG_OUT_EN
    @(posedge clk);
`endif
    #1;
  endtask

  // Scoreboard: pop one expectation and compare against the flag vector.
  task automatic check_flags(input string tag);
    logic [13:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL %s observed=%b expected=<queue empty>", tag, obs);
      return;
    end
    e = exp_q.pop_front();
    assert (obs === e) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, e);
    end
  endtask

  task automatic check_vec(input string tag, input logic [13:0] o, input logic [13:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic check_bit(input string tag, input logic o, input logic e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  logic [5:0] rtype_fn[4];
  logic [5:0] itype_op[8];

  initial begin
    checks   = 0;
    failures = 0;
    rtype_fn = '{6'b100001, 6'b100011, 6'b001000, 6'b001001};
    itype_op = '{6'b100011, 6'b101011, 6'b001101, 6'b001111,
                 6'b001000, 6'b000100, 6'b000010, 6'b000011};

    // Reset
    reset = 1'b0;
    Op    = 6'b000000;
    Func  = 6'b000000;
    repeat (2) @(posedge clk);
    #1;
    check_bit("rst_ill_seen", ill_seen, 1'b0);
`ifdef CTRL_REG_OUT_EN
    check_vec("rst_flags_clear", obs, 14'b0);
`endif
    @(negedge clk);
    reset = 1'b1;

    drive(6'b000000, 6'b000000);
    check_flags("nop");
    check_vec("nop_const", obs, 14'b10000000000000);
    check_bit("nop_ill_seen", ill_seen, 1'b0);

    // R-type instructions
    foreach (rtype_fn[i]) begin
      drive(6'b000000, rtype_fn[i]);
      check_flags($sformatf("rtype_fn_%b", rtype_fn[i]));
    end
    check_vec("jalr_const", obs, 14'b10001000000000);

    // I/J-type instructions with a non-zero Func that must be ignored
    foreach (itype_op[i]) begin
      drive(itype_op[i], 6'b100001);
      check_flags($sformatf("itype_op_%b", itype_op[i]));
    end
    check_vec("jal_const", obs, 14'b00000000000010);
    check_bit("legal_ill_seen", ill_seen, 1'b0);

    // Illegal R-type funct
    drive(6'b000000, 6'b100000);
    check_flags("rtype_bad_fn");
    check_bit("rtype_bad_ill_seen_pre", ill_seen, 1'b0);

    // Illegal opcode, then sticky behaviour
    drive(6'b000000, 6'b000000);
    check_flags("nop_again");
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    check_bit("clean_ill_seen", ill_seen, 1'b0);

    drive(6'b111111, 6'b000000);
    check_flags("op_111111");
    check_bit("ill_now", ill, 1'b1);
    check_bit("ill_seen_before_edge", ill_seen, 1'b0);
    @(posedge clk); #1;
    check_bit("ill_seen_after_edge", ill_seen, 1'b1);
    drive(6'b100011, 6'b000000);
    check_flags("lw_after_ill");
    @(posedge clk); #1;
    check_bit("ill_seen_holds", ill_seen, 1'b1);

    // Asynchronous clear, no clock edge in between
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check_bit("ill_seen_async_clear", ill_seen, 1'b0);
    #1;
    reset = 1'b1;

    // Reset wins over ill at the same edge, then sets after deassertion
    @(negedge clk);
    Op    = 6'b111111;
    Func  = 6'b000000;
    reset = 1'b0;
    @(posedge clk); #1;
    check_bit("reset_wins", ill_seen, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
`ifdef CTRL_REG_OUT_EN
    check_bit("reg_ill_seen_lag", ill_seen, 1'b0);
    @(posedge clk); #1;
`endif
    check_bit("ill_seen_after_release", ill_seen, 1'b1);

`ifdef CTRL_REG_OUT_EN
    // Registered output latency and asynchronous clear
    drive(6'b000000, 6'b000000);
    check_flags("reg_nop");
    @(negedge clk);
    Op   = 6'b101011;
    Func = 6'b000000;
    #1;
    check_bit("reg_sw_before_edge", sw, 1'b0);
    @(posedge clk); #1;
    check_bit("reg_sw_after_edge", sw, 1'b1);
    reset = 1'b0;
    #1;
    check_bit("reg_sw_async_clear", sw, 1'b0);
    #1;
    reset = 1'b1;
`endif

    // Exhaustive sweep of every Op/Func pair
    for (int k = 0; k < 4096; k++) begin
      logic [11:0] code;
      code = k[11:0];
      drive(code[11:6], code[5:0]);
      check_flags($sformatf("sweep_%b_%b", code[11:6], code[5:0]));
      checks++;
      assert ($countones(obs[12:1]) <= 1) else begin
        failures++;
        $error("FAIL sweep_onehot_%b observed=%b expected=at most one instruction flag", code, obs);
      end
    end

    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL queue_drain observed=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
